// File: rtl/inst_queue_pkg.sv
// Shared issue-mode encodings, reset polarity and pop-count helper for the
// fetch/decode instruction queue.
package inst_queue_pkg;

  localparam logic DUAL_ISSUE   = 1'b1;
  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic RST_ENABLE   = 1'b0;

  // Entries decode takes this cycle, clipped to what the queue actually holds.
  function automatic logic [1:0] pop_amount(input logic stall, input logic issue,
                                            input logic has1, input logic has2);
    if (stall || !has1) return 2'd0;
    if (issue == SINGLE_ISSUE || !has2) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// Dual-width fetch->decode instruction queue: push 0-2, pop 0-2 per cycle, 1-cycle fill latency.
// Backpressure: full_o asserts with fewer than 2 free slots; pushes while full are dropped.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     fetch_valid1_i,
  input  logic                     fetch_valid2_i,
  input  logic [AW-1:0]            fetch_addr1_i,
  input  logic [AW-1:0]            fetch_addr2_i,
  input  logic [DW-1:0]            fetch_inst1_i,
  input  logic [DW-1:0]            fetch_inst2_i,
  input  logic                     id_stall_i,
  input  logic                     issue_i,
  output logic                     inst1_valid_o,
  output logic                     inst2_valid_o,
  output logic [AW-1:0]            inst1_addr_o,
  output logic [AW-1:0]            inst2_addr_o,
  output logic [DW-1:0]            inst1_o,
  output logic [DW-1:0]            inst2_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] inst_q [DEPTH];

  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count, count_next;
  logic          push_ok;
  logic [1:0]    push_n, pop_n;

  // Full is judged on current occupancy only, so a same-cycle pop never admits a push.
  assign full_o  = count > CW'(DEPTH - 2);
  assign push_ok = fetch_valid1_i & ~full_o;
  assign push_n  = push_ok ? (fetch_valid2_i ? 2'd2 : 2'd1) : 2'd0;
  assign pop_n   = pop_amount(id_stall_i, issue_i, count != '0, count > CW'(1));

  assign head1      = head + PW'(1);
  assign tail1      = tail + PW'(1);
  assign count_next = count + CW'(push_n) - CW'(pop_n);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count_next;
    end
  end

  // Storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE && !flush && push_ok) begin
      addr_q[tail] <= fetch_addr1_i;
      inst_q[tail] <= fetch_inst1_i;
      if (fetch_valid2_i) begin
        addr_q[tail1] <= fetch_addr2_i;
        inst_q[tail1] <= fetch_inst2_i;
      end
    end
  end

  assign inst1_valid_o = count != '0;
  assign inst2_valid_o = count > CW'(1);
  assign inst1_addr_o  = inst1_valid_o ? addr_q[head]  : '0;
  assign inst1_o       = inst1_valid_o ? inst_q[head]  : '0;
  assign inst2_addr_o  = inst2_valid_o ? addr_q[head1] : '0;
  assign inst2_o       = inst2_valid_o ? inst_q[head1] : '0;
  assign count_o       = count;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: the driver records accepted pushes and expected pops
// in a reference queue; a negedge monitor compares every DUT view against it.
module tb_inst_queue;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        fetch_valid1_i = 1'b0, fetch_valid2_i = 1'b0;
  logic [31:0] fetch_addr1_i = '0, fetch_addr2_i = '0;
  logic [31:0] fetch_inst1_i = '0, fetch_inst2_i = '0;
  logic        id_stall_i = 1'b1, issue_i = 1'b0;
  logic        inst1_valid_o, inst2_valid_o;
  logic [31:0] inst1_addr_o, inst2_addr_o, inst1_o, inst2_o;
  logic        full_o;
  logic [3:0]  count_o;

  int total = 0;
  int bad = 0;
  int exp_proto = 0;
  int proto_seen = 0;
  bit checking = 0;
  ent_t exp_q[$];
  logic [31:0] na = 32'h0;

  inst_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid1_i(fetch_valid1_i), .fetch_valid2_i(fetch_valid2_i),
    .fetch_addr1_i(fetch_addr1_i), .fetch_addr2_i(fetch_addr2_i),
    .fetch_inst1_i(fetch_inst1_i), .fetch_inst2_i(fetch_inst2_i),
    .id_stall_i(id_stall_i), .issue_i(issue_i),
    .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o),
    .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
    .inst1_o(inst1_o), .inst2_o(inst2_o),
    .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: DUT state after each edge must equal the reference queue.
  always @(negedge clk) begin
    if (checking) begin
      int sz;
      sz = exp_q.size();
      chk("count", 32'(count_o), 32'(sz));
      chk("full", 32'(full_o), 32'(sz >= DEPTH - 1));
      chk("v1", 32'(inst1_valid_o), 32'(sz >= 1));
      chk("v2", 32'(inst2_valid_o), 32'(sz >= 2));
      chk("addr1", inst1_addr_o, sz >= 1 ? exp_q[0].a : 32'h0);
      chk("inst1", inst1_o,      sz >= 1 ? exp_q[0].i : 32'h0);
      chk("addr2", inst2_addr_o, sz >= 2 ? exp_q[1].a : 32'h0);
      chk("inst2", inst2_o,      sz >= 2 ? exp_q[1].i : 32'h0);
    end
  end

  // Protocol watch: fetch pushing while full is counted, then reconciled at the end.
  always @(posedge clk) begin
    if (rst && !flush && fetch_valid1_i && full_o) begin
      proto_seen++;
      $display("note: push while full at %0t", $time);
    end
  end

  task automatic step(input logic v1, input logic v2,
                      input logic [31:0] a1, input logic [31:0] i1,
                      input logic [31:0] a2, input logic [31:0] i2,
                      input logic stall, input logic iss, input logic fl, input logic rs);
    int sz;
    int pn;
    fetch_valid1_i = v1; fetch_valid2_i = v2;
    fetch_addr1_i = a1; fetch_inst1_i = i1;
    fetch_addr2_i = a2; fetch_inst2_i = i2;
    id_stall_i = stall; issue_i = iss; flush = fl; rst = rs;
    @(posedge clk);
    sz = exp_q.size();
    if (!rs || fl) begin
      exp_q.delete();
    end else begin
      if (!stall) begin
        pn = iss ? 2 : 1;
        if (pn > sz) pn = sz;
        repeat (pn) void'(exp_q.pop_front());
      end
      if (v1) begin
        if (sz >= DEPTH - 1) exp_proto++;
        else begin
          exp_q.push_back('{a: a1, i: i1});
          if (v2) exp_q.push_back('{a: a2, i: i2});
        end
      end
    end
    #1;
  endtask

  // Sequential-address helpers; instruction word tags the address.
  task automatic push2(input logic stall, input logic iss);
    step(1, 1, na, 32'h2400_0000 | na, na + 4, 32'h2400_0000 | (na + 4),
         stall, iss, 0, 1);
    na = na + 8;
  endtask

  task automatic push1(input logic stall, input logic iss);
    step(1, 0, na, 32'h2400_0000 | na, 32'h0, 32'h0, stall, iss, 0, 1);
    na = na + 4;
  endtask

  task automatic idle(input logic stall, input logic iss);
    step(0, 0, 0, 0, 0, 0, stall, iss, 0, 1);
  endtask

  task automatic drain();
    repeat (5) idle(0, 1);
  endtask

  initial begin
    // Reset, with garbage on the fetch bus that must be dropped.
    step(1, 1, 32'hdead, 32'hbeef, 32'hdea0, 32'hbee0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checking = 1;
    idle(1, 0);

    // Basic pair push then dual-issue pop.
    step(1, 1, 32'h100, 32'h24010001, 32'h104, 32'h24020002, 0, 1, 0, 1);
    idle(0, 1);
    idle(0, 1);

    // Fill to 7 under stall; an extra push must be ignored.
    na = 32'h300;
    push1(1, 0);
    repeat (3) push2(1, 0);
    push2(1, 0);
    drain();

    // Push 2 / pop 1 until full.
    na = 32'h200;
    for (int k = 0; k < 10 && exp_q.size() < DEPTH - 1; k++) push2(0, 0);
    drain();

    // Steady state at 6 entries with wrapping pointers.
    na = 32'h400;
    repeat (3) push2(1, 0);
    repeat (8) push2(0, 1);
    drain();

    // Flush with 5 entries and a concurrent push.
    na = 32'h500;
    push2(1, 0);
    push2(1, 0);
    push1(1, 0);
    step(1, 1, 32'h5f0, 32'h11111111, 32'h5f4, 32'h22222222, 1, 0, 1, 1);
    push1(1, 0);
    idle(1, 0);
    drain();

    // Single entry with dual issue: exactly one pops.
    na = 32'h600;
    push1(1, 0);
    idle(0, 1);
    idle(0, 1);

    // Mid-operation reset drops everything.
    push2(1, 0);
    step(1, 1, 32'h700, 32'h7, 32'h704, 32'h8, 0, 1, 0, 0);
    push1(1, 0);
    idle(0, 0);
    idle(0, 0);

    checking = 0;
    chk("proto_count", 32'(proto_seen), 32'(exp_proto));
    chk("proto_nonzero", 32'(proto_seen > 0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
